// File: rtl/spi_slave_regs_pkg.sv
// spi_slave_regs_pkg: shared FSM encoding and frame constants for the SPI register slave
package spi_slave_regs_pkg;
  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
  localparam int RW_BIT = 7;
  localparam logic [6:0] ID_ADDR = 7'h7F;
  localparam int FRAME_LEN = 16;
endpackage

// File: rtl/spi_slave_regs_sync_edge.sv
// spi_sync_edge: 3-flop synchroniser with rise/fall detection on the synchronised level
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  logic [2:0] s_q;
  // shift the async pin through three flops; the first two resolve metastability
  always_ff @(posedge clk)
    s_q <= reset ? {3{RST_VAL}} : {s_q[1:0], d_i};
  assign q_o = s_q[1];
  assign rise_o = s_q[1] & ~s_q[2];
  assign fall_o = ~s_q[1] & s_q[2];
endmodule

// File: rtl/spi_slave_regs.sv
// spi_slave_regs: SPI mode-0 slave giving an SPI master read/write access to a fabric register bank
module spi_slave_regs
  import spi_slave_regs_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter logic [7:0] ID_VALUE = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_sclk,
  input  logic                  spi_ss_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  output logic [NUM_REGS*8-1:0] reg_q,
  output logic                  wr_stb,
  output logic [6:0]            wr_addr,
  output logic [7:0]            wr_data,
  output logic                  rd_stb
);
  localparam logic [7:0] NREG = 8'(NUM_REGS);
  logic sclk_s, sclk_rise, sclk_fall, ss_s, ss_rise, ss_fall;
  logic [1:0] mosi_q;
  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [6:0] sh_q, sh_d, addr_q, addr_d, wr_addr_q, wr_addr_d;
  logic [7:0] rd_sh_q, rd_sh_d, wr_data_q, wr_data_d, mosi_byte, rd_val;
  logic rw_q, rw_d, miso_q, miso_d, wr_stb_q, wr_stb_d, rd_stb_q, rd_stb_d, arm_q, arm_d;
  logic [1:0] settle_q, settle_d;
  logic [NUM_REGS*8-1:0] regs_q, regs_d;
  spi_sync_edge #(.RST_VAL(1'b0)) u_sclk (
    .clk(clk), .reset(reset), .d_i(spi_sclk), .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  spi_sync_edge #(.RST_VAL(1'b1)) u_ss (
    .clk(clk), .reset(reset), .d_i(spi_ss_n), .q_o(ss_s), .rise_o(ss_rise), .fall_o(ss_fall)
  );
  // MOSI only needs the level, so a plain 2-flop synchroniser aligned with the sclk/ss level taps
  always_ff @(posedge clk)
    mosi_q <= reset ? 2'b00 : {mosi_q[0], spi_mosi};
  assign mosi_byte = {sh_q, mosi_q[1]};
  assign rd_val = {1'b0, mosi_byte[6:0]} < NREG ? regs_q[{mosi_byte[6:0], 3'b000} +: 8] :
                  mosi_byte[6:0] == ID_ADDR ? ID_VALUE : 8'h00;
  // after reset ss_n must be seen high on real pin samples before a fall may open a frame,
  // so a reset in the middle of a frame does not re-enter that frame half way through
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    rw_d = rw_q;
    addr_d = addr_q;
    rd_sh_d = rd_sh_q;
    miso_d = miso_q;
    regs_d = regs_q;
    wr_stb_d = 1'b0;
    rd_stb_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    settle_d = settle_q[1] ? settle_q : settle_q + 2'd1;
    arm_d = arm_q | (settle_q[1] & ss_s);
    if (ss_rise) begin
      state_d = IDLE;
      miso_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          miso_d = 1'b0;
          if (ss_fall && arm_q && !sclk_s) begin
            state_d = CMD;
            cnt_d = '0;
          end
        end
        CMD: if (sclk_rise) begin
          sh_d = mosi_byte[6:0];
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(FRAME_LEN / 2 - 1)) begin
            rw_d = mosi_byte[RW_BIT];
            addr_d = mosi_byte[6:0];
            rd_sh_d = mosi_byte[RW_BIT] ? rd_val : 8'h00;
            rd_stb_d = mosi_byte[RW_BIT];
            state_d = DATA;
          end
        end
        DATA: if (sclk_rise) begin
          sh_d = mosi_byte[6:0];
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(FRAME_LEN - 1)) begin
            if (!rw_q && {1'b0, addr_q} < NREG) begin
              regs_d[{addr_q, 3'b000} +: 8] = mosi_byte;
              wr_stb_d = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = mosi_byte;
            end
            miso_d = 1'b0;
            state_d = DONE;
          end
        end else if (sclk_fall) begin
          miso_d = rd_sh_q[7];
          rd_sh_d = {rd_sh_q[6:0], 1'b0};
        end
        default: miso_d = 1'b0;
      endcase
    end
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sh_q <= '0;
      rw_q <= 1'b0;
      addr_q <= '0;
      rd_sh_q <= '0;
      miso_q <= 1'b0;
      regs_q <= '0;
      wr_stb_q <= 1'b0;
      rd_stb_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      settle_q <= '0;
      arm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      rw_q <= rw_d;
      addr_q <= addr_d;
      rd_sh_q <= rd_sh_d;
      miso_q <= miso_d;
      regs_q <= regs_d;
      wr_stb_q <= wr_stb_d;
      rd_stb_q <= rd_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      settle_q <= settle_d;
      arm_q <= arm_d;
    end
  end
  assign spi_miso = miso_q;
  assign spi_miso_oe = ~ss_s;
  assign reg_q = regs_q;
  assign wr_stb = wr_stb_q;
  assign rd_stb = rd_stb_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
endmodule

// File: tb/tb_spi_slave_regs.sv
// tb_spi_slave_regs: directed SPI frames against spi_slave_regs with immediate-assertion checks
module tb_spi_slave_regs;
  localparam int H = 4;
  logic clk = 1'b0, reset = 1'b1, spi_sclk = 1'b0, spi_ss_n = 1'b1, spi_mosi = 1'b0;
  logic spi_miso, spi_miso_oe, wr_stb, rd_stb;
  logic [63:0] reg_q;
  logic [6:0] wr_addr, last_wa = '0;
  logic [7:0] wr_data, last_wd = '0;
  int wr_n = 0, rd_n = 0, vectors = 0, miscompares = 0;
  spi_slave_regs #(.NUM_REGS(8), .ID_VALUE(8'hA5)) dut (
    .clk(clk), .reset(reset), .spi_sclk(spi_sclk), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .reg_q(reg_q), .wr_stb(wr_stb),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_stb(rd_stb)
  );
  always #10 clk = ~clk;
  always @(posedge clk) begin
    if (wr_stb) begin
      wr_n <= wr_n + 1;
      last_wa <= wr_addr;
      last_wd <= wr_data;
    end
    if (rd_stb) rd_n <= rd_n + 1;
  end
  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic frame(input logic [15:0] tx, input int nclk, input int rst_at,
                       output logic [7:0] rx, output logic extra);
    rx = '0;
    extra = 1'b0;
    spi_ss_n = 1'b0;
    for (int i = 0; i < nclk; i++) begin
      if (i == rst_at) begin
        reset = 1'b1;
        clks(2);
        chk("rst_mid_reg_q", reg_q, 64'h0);
        chk("rst_mid_outs", {spi_miso, spi_miso_oe, wr_stb, rd_stb}, 4'b0000);
        chk("rst_mid_wr", {wr_addr, wr_data}, 15'h0);
        clks(1);
        reset = 1'b0;
      end
      spi_mosi = i < 16 ? tx[15-i] : 1'b0;
      clks(H);
      spi_sclk = 1'b1;
      if (i >= 8 && i < 16) rx[15-i] = spi_miso;
      if (i >= 16) extra = extra | spi_miso;
      clks(H);
      spi_sclk = 1'b0;
    end
    clks(H);
    spi_ss_n = 1'b1;
    clks(H);
  endtask
  logic [7:0] rx;
  logic ex;
  int w0, r0;
  logic [63:0] model;
  logic [7:0] vals [4];
  initial begin
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    clks(3);
    chk("reset_reg_q", reg_q, 64'h0);
    chk("reset_outs", {spi_miso, spi_miso_oe, wr_stb, rd_stb}, 4'b0000);
    chk("reset_wr", {wr_addr, wr_data}, 15'h0);
    reset = 1'b0;
    clks(6);
    frame(16'h035C, 16, -1, rx, ex);
    chk("wr3_count", 64'(wr_n), 64'd1);
    chk("wr3_addr_data", {last_wa, last_wd}, {7'd3, 8'h5C});
    chk("wr3_reg", reg_q, 64'h0000_0000_5C00_0000);
    r0 = rd_n;
    frame(16'h8300, 16, -1, rx, ex);
    chk("rd3_data", rx, 8'h5C);
    chk("rd3_stb", 64'(rd_n - r0), 64'd1);
    r0 = rd_n;
    w0 = wr_n;
    frame(16'hFF00, 16, -1, rx, ex);
    chk("rd_id", rx, 8'hA5);
    chk("rd_id_stb", 64'(rd_n - r0), 64'd1);
    chk("rd_id_no_wr", 64'(wr_n - w0), 64'd0);
    w0 = wr_n;
    frame(16'h1077, 16, -1, rx, ex);
    chk("wr_oob_no_stb", 64'(wr_n - w0), 64'd0);
    chk("wr_oob_reg", reg_q, 64'h0000_0000_5C00_0000);
    frame(16'h9000, 16, -1, rx, ex);
    chk("rd_oob", rx, 8'h00);
    w0 = wr_n;
    frame(16'h7F12, 16, -1, rx, ex);
    chk("wr_id_no_stb", 64'(wr_n - w0), 64'd0);
    w0 = wr_n;
    frame(16'h01FF, 12, -1, rx, ex);
    chk("abort_no_stb", 64'(wr_n - w0), 64'd0);
    chk("abort_reg", reg_q, 64'h0000_0000_5C00_0000);
    frame(16'h013C, 16, -1, rx, ex);
    chk("after_abort_stb", 64'(wr_n - w0), 64'd1);
    chk("after_abort_reg", reg_q, 64'h0000_0000_5C00_3C00);
    frame(16'h8100, 16, -1, rx, ex);
    chk("rd1", rx, 8'h3C);
    w0 = wr_n;
    frame(16'h8300, 20, -1, rx, ex);
    chk("extra_clk_data", rx, 8'h5C);
    chk("extra_clk_miso0", 64'(ex), 64'd0);
    chk("extra_clk_no_wr", 64'(wr_n - w0), 64'd0);
    w0 = wr_n;
    frame(16'h02AA, 16, 11, rx, ex);
    chk("rst_mid_no_stb", 64'(wr_n - w0), 64'd0);
    chk("rst_mid_reg_after", reg_q, 64'h0);
    frame(16'h02AA, 16, -1, rx, ex);
    chk("post_rst_wr", reg_q, 64'h0000_0000_00AA_0000);
    model = 64'h0000_0000_00AA_0000;
    w0 = wr_n;
    for (int i = 0; i < 4; i++) begin
      frame({8'(4 + i), vals[i]}, 16, -1, rx, ex);
      model[(4 + i) * 8 +: 8] = vals[i];
    end
    chk("maxrate_wr_count", 64'(wr_n - w0), 64'd4);
    chk("maxrate_reg", reg_q, model);
    chk("maxrate_model", model, 64'h4433_2211_00AA_0000);
    for (int i = 0; i < 4; i++) begin
      frame({8'(8'h84 + i), 8'h00}, 16, -1, rx, ex);
      chk("maxrate_rd", rx, vals[i]);
    end
    frame(16'h8200, 16, -1, rx, ex);
    chk("maxrate_rd2", rx, 8'hAA);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/spi_slave_regs.md
# spi_slave_regs

SPI mode-0 responder that lets the HPS SPI master (SPIM1, routed to a GPIO header) read and write a small bank of FPGA-fabric control registers. The block oversamples the SPI pins in the 50 MHz fabric clock domain, decodes one command byte plus one data byte per chip-select frame, and exposes the register contents and a write strobe to fabric logic. It sits beside the debounce and PIO logic in the top level, with the register outputs driving fabric control.

## Interface
- NUM_REGS, 8: number of read/write registers, 1..64, at addresses 0..NUM_REGS-1.
- ID_VALUE, 8'hA5: constant returned on reads of address 7'h7F.
- clk  in  1  fabric clock, fpga_clk1_50 domain, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- spi_sclk  in  1  SPI clock from the master, asynchronous, idle low.
- spi_ss_n  in  1  chip select, active low, asynchronous.
- spi_mosi  in  1  master-out data, asynchronous.
- spi_miso  out  1  slave-out data.
- spi_miso_oe  out  1  MISO output enable, high while a frame is active.
- reg_q  out  NUM_REGS*8  flat register contents; register n at bits [8n+7:8n].
- wr_stb  out  1  one-cycle pulse when a write commits.
- wr_addr  out  7  address of the last committed write.
- wr_data  out  8  data of the last committed write.
- rd_stb  out  1  one-cycle pulse when a read command is decoded.

## Operation
- Synchronisation: sclk, ss_n and mosi each pass through a 2-flop synchroniser. sclk and ss_n also get a third flop to detect rising and falling edges. All decisions use the synchronised signals.
- Frame: ss_n falls, then 16 SCLK cycles, MSB first.
  - Byte 0 is {rw, addr[6:0]}; rw=1 means read.
  - Byte 1 is write data (MOSI) or read data (MISO).
- Mode 0 timing: MOSI is sampled on each synchronised SCLK rise. MISO changes on each synchronised SCLK fall.
- States:
  - IDLE: MISO=0. On ss_n fall, clear the bit counter and go to CMD.
  - CMD: shift MOSI on each rise. After the 8th rise, latch rw/addr. If rw=1, load the read shifter and pulse rd_stb. Go to DATA.
  - DATA: on each fall, present the next read-shifter bit on MISO (the MSB appears on the 8th fall). On each rise, shift MOSI. After the 16th rise, if rw=0 and addr<NUM_REGS, write the register, pulse wr_stb and update wr_addr/wr_data in the same cycle. Go to DONE.
  - DONE: ignore further SCLK edges, MISO=0. On ss_n rise, go to IDLE.
- ss_n rise from any state returns to IDLE the next cycle. A frame aborted before the 16th rise commits nothing.
- Read data:
  - addr<NUM_REGS returns the register value.
  - 7'h7F returns ID_VALUE.
  - Any other address returns 8'h00.
  - The value is captured at the 8th rise. A write committed later does not alter bits already being shifted.
- Writes to addr≥NUM_REGS, including 7'h7F, are ignored: no wr_stb.
- spi_miso_oe equals the inverted synchronised ss_n.

## Timing
- Reset values: all registers 0, reg_q=0, spi_miso=0, spi_miso_oe=0, wr_stb=0, rd_stb=0, wr_addr=0, wr_data=0, state IDLE.
- Reset mid-frame returns the block to IDLE. The rest of that frame is ignored until ss_n goes high and falls again.
- Pin-to-decision latency is 3 clk (sync + edge detect).
- MISO update: 1 clk after the falling edge is detected, i.e. ≤4 clk after the SCLK fall at the pin.
- reg_q updates in the same cycle wr_stb is high, 4 clk after the 16th SCLK rise at the pin.
- SCLK limit: ≤ clk/8 (6.25 MHz) with each SCLK phase ≥4 clk. ss_n setup to the first SCLK rise and hold after the last fall: ≥4 clk.
- A simultaneous ss_n rise and SCLK edge in the same synchronised cycle resolves to the ss_n rise (abort).

## Structure
- Package spi_slave_regs_pkg holds:
  - the state encoding (IDLE, CMD, DATA, DONE);
  - RW_BIT index 7;
  - ID_ADDR = 7'h7F;
  - frame length constant 16.
- Sub-module spi_sync_edge: 3-flop synchroniser with rise/fall outputs. It is instantiated for sclk and ss_n; mosi uses only the 2-flop path.

## Test plan
- Write frame 8'h03, 8'h5C, then read frame 8'h83 → MISO returns 8'h5C. wr_stb pulses once with wr_addr=3, wr_data=8'h5C, and reg_q[31:24]=8'h5C.
- Read 8'hFF (address 7F) → MISO returns 8'hA5. rd_stb pulses once and wr_stb never pulses.
- Write to address 7'h10 with NUM_REGS=8 → no wr_stb and reg_q unchanged. A read of 7'h10 returns 8'h00.
- Abort: raise ss_n after 12 SCLK cycles of write frame 8'h01, 8'hFF → no wr_stb and register 1 unchanged. The next full frame behaves normally.
- Extra clocks and reset: 20 SCLK cycles in one frame → only the first 16 count and MISO=0 after bit 16. Asserting reset during DATA → outputs return to reset values and the frame is not committed.
- Max-rate frames at SCLK = clk/8, back-to-back with the minimum ss_n high time → all writes and reads bit-exact.
